fifo_merge_cmp: RTL and testbench
=================================

Name: fifo_merge_cmp

Overview:
- Two-lane buffered merge stage that feeds the team's N-bit magnitude comparator.
- Each input lane (A, B) has its own small FIFO.
- Each cycle the block compares the two FIFO heads, forwards the smaller value (unsigned) to a registered valid/ready output, and pops that lane.
- Used ahead of downstream compare/sort logic to interleave two pre-sorted streams into one sorted stream.

Parameters:
- BITS, 16, data width of both lanes and of the output.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, at least 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  lane A data valid.
- a_data  in  BITS  lane A data.
- a_ready  out  1  lane A can accept.
- b_valid  in  1  lane B data valid.
- b_data  in  BITS  lane B data.
- b_ready  out  1  lane B can accept.
- out_valid  out  1  output register holds a word.
- out_data  out  BITS  merged word.
- out_src  out  1  source lane of out_data; 0 = A, 1 = B.
- out_ready  in  1  downstream accepts out_data this cycle.
- a_count  out  AW+1  lane A FIFO occupancy, 0..DEPTH.
- b_count  out  AW+1  lane B FIFO occupancy, 0..DEPTH.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n; the polarity and synchronicity are fixed.
- While rst_n=0:
  - FIFO pointers and counts clear to 0.
  - out_valid=0, out_data=0, out_src=0.
  - a_ready=b_ready=0 (gated by rst_n).
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all buffered and output data immediately, with no partial transfer.
- Ready rules:
  - x_ready = rst_n AND (x_count != DEPTH). Computed combinationally from the registered count only; it never depends on the same-cycle pop.
  - Push on lane x occurs when x_valid AND x_ready at the rising edge; the word is written at the write pointer and the write pointer increments, wrapping modulo DEPTH.
  - Data offered while x_ready=0 is not captured; the upstream must hold it.
- Load decision, evaluated on registered state each cycle:
  - can_load = (!out_valid OR out_ready) AND (a_count != 0 OR b_count != 0).
  - Selection when both lanes are non-empty: pick A if headA <= headB (unsigned, tie goes to A), otherwise pick B.
  - If only one lane is non-empty, pick that lane.
- On a rising edge with can_load:
  - out_data <= selected head; out_src <= selected lane; out_valid <= 1.
  - The selected FIFO pops: read pointer increments, wrapping modulo DEPTH.
- On a rising edge with out_valid AND out_ready AND no load: out_valid <= 0. out_data and out_src hold their last value.
- With out_valid=1 AND out_ready=0: out_data, out_src and out_valid hold, and neither FIFO pops (backpressure).
- Latency: a word pushed at edge N is visible at the head after edge N; the earliest it can appear on out_data is after edge N+1, i.e. two cycles from input to output.
- Throughput: one word per cycle when out_ready is held high and data is available.
- Simultaneous push and pop on the same lane in one edge is legal; the count is unchanged.
- Push into a full lane cannot occur, even if the same lane pops that cycle (conservative ready).
- Counts:
  - x_count increments on a push only, decrements on a pop only, and is unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- No lookahead: the merge never waits for an empty lane to fill. If B is empty, A drains regardless of ordering.
- Pointer wrap-around must be exercised. Full/empty is derived from the count, not from pointer equality.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, out_valid=0, counts 0. Release rst_n -> a_ready=b_ready=1 next cycle.
- Sorted merge: push A=1,4,9 and B=2,3,10 with out_ready=1 -> out_data sequence 1,2,3,4,9,10 with out_src 0,1,1,0,0,1, and out_valid stays continuous once both lanes are primed.
- Tie and single-lane: push A=16 and B=16, then only A=21 -> outputs 16(src 0), 16(src 1), 21(src 0).
- Full/backpressure: out_ready=0, push 5 words into lane A with DEPTH=4 -> the first word moves to the output register, 4 words are buffered, a_count=4, a_ready=0. The 6th word is stalled with no overwrite. Raise out_ready -> all words drain in order, and a_ready returns to 1 after the first pop.
- Wrap-around: stream 10 words through lane A (values 100..109) with out_ready=1 -> pointers wrap twice and the output is exactly 100..109.
- Reset mid-operation: with a_count=3 and out_valid=1, pulse rst_n low between clock edges -> out_valid drops immediately, counts read 0, and no stale word appears after release.

Source files
------------

// File: rtl/fifo_merge_cmp.sv
// fifo_merge_cmp: two-lane buffered merge stage.
//
// Each lane (A, B) feeds its own DEPTH-entry FIFO. Each cycle the two FIFO heads
// are compared. The smaller one (unsigned; a tie goes to A) is moved into a
// registered valid/ready output and its lane is popped. If only one lane holds
// data, that lane drains without waiting for the other one. Two pre-sorted
// streams therefore come out as one sorted stream.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   a_valid/a_data/a_ready lane A push handshake
//   b_valid/b_data/b_ready lane B push handshake
//   out_valid/out_data/out_src/out_ready  merged output (out_src: 0 = A, 1 = B)
//   a_count, b_count      lane FIFO occupancy, 0..DEPTH
module fifo_merge_cmp #(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DEPTH = 4,   // power of 2, >= 2
    parameter int unsigned AW    = 2    // log2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid,
    input  logic [BITS-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [BITS-1:0] b_data,
    output logic            b_ready,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            out_src,
    input  logic            out_ready,
    output logic [AW:0]     a_count,
    output logic [AW:0]     b_count
);

    localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CntOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    // Lane storage: no reset, contents are don't-care until written.
    logic [BITS-1:0] a_mem_q [DEPTH];
    logic [BITS-1:0] b_mem_q [DEPTH];

    logic [AW-1:0]   a_wr_q, a_wr_d, a_rd_q, a_rd_d;
    logic [AW-1:0]   b_wr_q, b_wr_d, b_rd_q, b_rd_d;
    logic [AW:0]     a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic            out_src_q, out_src_d;

    logic            a_push, b_push, a_pop, b_pop;
    logic            a_nonempty, b_nonempty;
    logic            can_load, sel_b;
    logic [BITS-1:0] a_head, b_head, sel_head;

    // Ready is based on the registered count only, so a lane that pops this
    // cycle still refuses a push while full.
    assign a_ready = rst_n && (a_cnt_q != CntFull);
    assign b_ready = rst_n && (b_cnt_q != CntFull);

    assign a_push = a_valid && a_ready;
    assign b_push = b_valid && b_ready;

    assign a_nonempty = (a_cnt_q != '0);
    assign b_nonempty = (b_cnt_q != '0);

    assign a_head = a_mem_q[a_rd_q];
    assign b_head = b_mem_q[b_rd_q];

    assign can_load = (!out_valid_q || out_ready) && (a_nonempty || b_nonempty);

    // B wins only if it has data and A is empty or strictly larger.
    assign sel_b    = b_nonempty && (!a_nonempty || (b_head < a_head));
    assign sel_head = sel_b ? b_head : a_head;

    assign a_pop = can_load && !sel_b;
    assign b_pop = can_load && sel_b;

    always_comb begin
        a_wr_d      = a_wr_q;
        a_rd_d      = a_rd_q;
        a_cnt_d     = a_cnt_q;
        b_wr_d      = b_wr_q;
        b_rd_d      = b_rd_q;
        b_cnt_d     = b_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        // Pointers wrap naturally because DEPTH == 2**AW.
        if (a_push) a_wr_d = a_wr_q + PtrOne;
        if (a_pop)  a_rd_d = a_rd_q + PtrOne;
        if (b_push) b_wr_d = b_wr_q + PtrOne;
        if (b_pop)  b_rd_d = b_rd_q + PtrOne;

        unique case ({a_push, a_pop})
            2'b10:   a_cnt_d = a_cnt_q + CntOne;
            2'b01:   a_cnt_d = a_cnt_q - CntOne;
            default: a_cnt_d = a_cnt_q;
        endcase

        unique case ({b_push, b_pop})
            2'b10:   b_cnt_d = b_cnt_q + CntOne;
            2'b01:   b_cnt_d = b_cnt_q - CntOne;
            default: b_cnt_d = b_cnt_q;
        endcase

        if (can_load) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_head;
            out_src_d   = sel_b;
        end else if (out_valid_q && out_ready) begin
            // Word consumed with nothing to replace it; data/src keep last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wr_q      <= '0;
            a_rd_q      <= '0;
            a_cnt_q     <= '0;
            b_wr_q      <= '0;
            b_rd_q      <= '0;
            b_cnt_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            a_wr_q      <= a_wr_d;
            a_rd_q      <= a_rd_d;
            a_cnt_q     <= a_cnt_d;
            b_wr_q      <= b_wr_d;
            b_rd_q      <= b_rd_d;
            b_cnt_q     <= b_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_push) a_mem_q[a_wr_q] <= a_data;
        if (b_push) b_mem_q[b_wr_q] <= b_data;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign a_count   = a_cnt_q;
    assign b_count   = b_cnt_q;

endmodule

// File: tb/tb_fifo_merge_cmp.sv
// Self-checking bench for fifo_merge_cmp: a cycle-exact vector table for the
// sorted merge, plus hand-written sequences (tie, backpressure, wrap, reset)
// whose output words are checked against a scoreboard queue.
module tb_fifo_merge_cmp;

    localparam int BITS  = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_valid = 1'b0;
    logic [BITS-1:0] a_data = '0;
    logic            a_ready;
    logic            b_valid = 1'b0;
    logic [BITS-1:0] b_data = '0;
    logic            b_ready;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            out_src;
    logic            out_ready = 1'b0;
    logic [AW:0]     a_count;
    logic [AW:0]     b_count;

    always #5 clk = ~clk;

    fifo_merge_cmp #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .a_count   (a_count),
        .b_count   (b_count)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [BITS-1:0] d;
        logic            s;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    typedef struct {
        logic            av;
        logic [BITS-1:0] ad;
        logic            bv;
        logic [BITS-1:0] bd;
        logic            ordy;
        logic            ov;
        logic [BITS-1:0] od;
        logic            os;
        logic [AW:0]     ac;
        logic [AW:0]     bc;
    } vec_t;

    vec_t tbl[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_word(input int d, input logic s);
        exp_t e;
        e.d = BITS'(d);
        e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < budget) begin
            tick();
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, out_valid, 0);
    endtask

    // Scoreboard: every output handshake must match the next expected word.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got data %0d src %0d, expected no output",
                         out_data, out_src);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.d || out_src !== mon_e.s) begin
                    n_fail++;
                    $display("FAIL sb_word: got data %0d src %0d, expected data %0d src %0d",
                             out_data, out_src, mon_e.d, mon_e.s);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Sorted merge, one row per clock edge: inputs before the edge,
        // expected registered state after it.
        tbl[0] = '{1'b1, 16'd1, 1'b1, 16'd2,  1'b1, 1'b0, 16'd0,  1'b0, 3'd1, 3'd1};
        tbl[1] = '{1'b1, 16'd4, 1'b1, 16'd3,  1'b1, 1'b1, 16'd1,  1'b0, 3'd1, 3'd2};
        tbl[2] = '{1'b1, 16'd9, 1'b1, 16'd10, 1'b1, 1'b1, 16'd2,  1'b1, 3'd2, 3'd2};
        tbl[3] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd3,  1'b1, 3'd2, 3'd1};
        tbl[4] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd4,  1'b0, 3'd1, 3'd1};
        tbl[5] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd9,  1'b0, 3'd0, 3'd1};
        tbl[6] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd10, 1'b1, 3'd0, 3'd0};
        tbl[7] = '{1'b0, 16'd0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd10, 1'b1, 3'd0, 3'd0};

        // ---- Reset with valids asserted ----
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        a_data    = 16'hffff;
        b_data    = 16'hffff;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_a_count", a_count, 0);
        check("rst_b_count", b_count, 0);
        rst_n   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        check("rel_a_ready", a_ready, 1);
        check("rel_b_ready", b_ready, 1);
        check("rel_out_data", out_data, 0);

        // ---- Sorted merge, cycle-exact ----
        expect_word(1, 1'b0);
        expect_word(2, 1'b1);
        expect_word(3, 1'b1);
        expect_word(4, 1'b0);
        expect_word(9, 1'b0);
        expect_word(10, 1'b1);
        for (int i = 0; i < 8; i++) begin
            a_valid   = tbl[i].av;
            a_data    = tbl[i].ad;
            b_valid   = tbl[i].bv;
            b_data    = tbl[i].bd;
            out_ready = tbl[i].ordy;
            tick();
            check($sformatf("merge_row%0d", i),
                  {6'd0, out_valid, out_data, out_src, a_count, b_count, a_ready, b_ready},
                  {6'd0, tbl[i].ov, tbl[i].od, tbl[i].os, tbl[i].ac, tbl[i].bc,
                   tbl[i].ac != 3'(DEPTH), tbl[i].bc != 3'(DEPTH)});
        end
        check("merge_sb_empty", exp_q.size(), 0);

        // ---- Tie goes to A, then single-lane drain ----
        expect_word(16, 1'b0);
        expect_word(16, 1'b1);
        expect_word(21, 1'b0);
        out_ready = 1'b1;
        a_valid   = 1'b1;
        a_data    = 16'd16;
        b_valid   = 1'b1;
        b_data    = 16'd16;
        tick();
        b_valid = 1'b0;
        a_data  = 16'd21;
        tick();
        a_valid = 1'b0;
        wait_drain("tie", 20);

        // ---- Full lane with output backpressure ----
        for (int v = 50; v <= 55; v++) expect_word(v, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1;
            a_data  = BITS'(50 + i);
            tick();
        end
        a_data = 16'd55;
        check("full_a_count", a_count, 4);
        check("full_a_ready", a_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_data", out_data, 50);
        tick();
        tick();
        check("stall_a_count", a_count, 4);
        check("stall_out_data", out_data, 50);
        out_ready = 1'b1;
        tick();
        check("unfull_a_ready", a_ready, 1);
        check("unfull_a_count", a_count, 3);
        check("unfull_out_data", out_data, 51);
        tick();
        a_valid = 1'b0;
        wait_drain("full", 30);

        // ---- Pointer wrap-around on lane A ----
        for (int v = 100; v <= 109; v++) expect_word(v, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1;
            a_data  = BITS'(100 + i);
            tick();
        end
        a_valid = 1'b0;
        wait_drain("wrap", 30);
        check("wrap_a_count", a_count, 0);

        // ---- Asynchronous reset mid-operation ----
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = BITS'(70 + i);
            tick();
        end
        a_valid = 1'b0;
        check("pre_rst_a_count", a_count, 3);
        check("pre_rst_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_a_count", a_count, 0);
        check("mid_rst_a_ready", a_ready, 0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_a_count", a_count, 0);
        check("post_rst_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
